// File: rtl/sample_counter_multi.sv
// sample_counter_multi
//   Multi-channel sample-address counter. Each channel is kicked by its own go,
//   advances once per shared sample tick (en) through ROM addresses 0..L-1,
//   then returns to idle, or wraps when looping is built in and selected.
//   Effective length L is len_i, or MAXCOUNT when len_i is 0 or exceeds MAXCOUNT.
//   Per-cycle priority per channel: go > stop > en-step.
//
//   Optional feature macro: SAMPLE_LOOP_EN
//     defined   : loop_i=1 at the terminal step wraps to 0 and keeps playing
//     undefined : loop is ignored and every channel stops at its terminal step
//
// Ports
//   clk     in   1               system clock, all state on posedge
//   resetn  in   1               asynchronous active-low reset
//   en      in   1               shared sample tick
//   go      in   CHANNELS        per-channel (re)trigger, level sampled
//   stop    in   CHANNELS        per-channel abort
//   len     in   CHANNELS*WIDTH  per-channel length, ch i at [i*WIDTH +: WIDTH]
//   loop    in   CHANNELS        per-channel loop select
//   count   out  CHANNELS*WIDTH  per-channel ROM address, same packing as len
//   active  out  CHANNELS        channel is in PLAY
//   done    out  CHANNELS        one-cycle pulse when a channel finishes or wraps
//   busy    out  1               OR of active
module sample_counter_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MAXCOUNT = 43840
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       go,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS*WIDTH-1:0] len,
  input  logic [CHANNELS-1:0]       loop,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       done,
  output logic                      busy
);

  localparam logic [0:0]       IDLE  = 1'b0;
  localparam logic [0:0]       PLAY  = 1'b1;
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAXCOUNT);

  // Zero or oversized lengths fall back to the longest supported sample.
  function automatic logic [WIDTH-1:0] eff_len(input logic [WIDTH-1:0] l);
    if (l == '0 || l > MAX_L) return MAX_L;
    return l;
  endfunction

  logic [CHANNELS-1:0] loop_keep;
`ifdef SAMPLE_LOOP_EN
  assign loop_keep = loop;
`else
  logic unused_loop;
  assign unused_loop = ^loop;
  assign loop_keep   = '0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic             done_r;
    logic [WIDTH-1:0] last;

    // len is live: a change mid-play moves the terminal address immediately.
    assign last = eff_len(len[g*WIDTH +: WIDTH]) - WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state  <= IDLE;
        cnt    <= '0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (go[g]) begin
          state <= PLAY;
          cnt   <= '0;
        end else if (stop[g]) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (state == PLAY && en) begin
          // >= rather than == so a shortened len can never leave cnt past L-1.
          if (cnt >= last) begin
            cnt    <= '0;
            done_r <= 1'b1;
            state  <= loop_keep[g] ? PLAY : IDLE;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
      end
    end

    assign count[g*WIDTH +: WIDTH] = cnt;
    assign active[g]               = (state == PLAY);
    assign done[g]                 = done_r;
  end

  assign busy = |active;

endmodule

// File: tb/tb_sample_counter_multi.sv
// Directed bench for sample_counter_multi (WIDTH=16, CHANNELS=4, MAXCOUNT=43840).
module tb_sample_counter_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  go, stop, loop;
  logic [63:0] len;
  logic [63:0] count;
  logic [3:0]  active, done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sample_counter_multi #(.WIDTH(16), .CHANNELS(4), .MAXCOUNT(43840)) dut (
    .clk(clk), .resetn(resetn), .en(en), .go(go), .stop(stop), .len(len),
    .loop(loop), .count(count), .active(active), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(count[ch*16 +: 16]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; go = '0; stop = '0; loop = '0; len = '0;
    #3;
    chk("rst_count", count[31:0], 0);
    chk("rst_count_hi", count[63:32], 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    #4 resetn = 1'b1;
    step();

    // len0=3 single pass
    len[15:0] = 16'd3;
    go[0] = 1'b1; step(); go[0] = 1'b0;
    chk("t2_start_cnt", cnt_of(0), 0);
    chk("t2_start_act", 32'(active[0]), 1);
    chk("t2_busy", 32'(busy), 1);
    en = 1'b1;
    step(); chk("t2_c1", cnt_of(0), 1); chk("t2_d1", 32'(done[0]), 0);
    step(); chk("t2_c2", cnt_of(0), 2); chk("t2_d2", 32'(done[0]), 0);
    step(); chk("t2_c3", cnt_of(0), 0); chk("t2_d3", 32'(done[0]), 1);
    chk("t2_act3", 32'(active[0]), 0);
    step(); chk("t2_c4", cnt_of(0), 0); chk("t2_d4", 32'(done[0]), 0);
    chk("t2_act4", 32'(active[0]), 0);
    chk("t2_others", count[63:16], 0);
    chk("t2_busy_end", 32'(busy), 0);
    en = 1'b0;

    // reset mid-play at count 5
    len[15:0] = 16'd10;
    go[0] = 1'b1; step(); go[0] = 1'b0;
    en = 1'b1; repeat (5) step(); en = 1'b0;
    chk("t1_pre", cnt_of(0), 5);
    #2 resetn = 1'b0;
    #1;
    chk("t1_cnt", cnt_of(0), 0);
    chk("t1_act", 32'(active[0]), 0);
    chk("t1_done", 32'(done[0]), 0);
    #1 resetn = 1'b1;
    step();

    // go and en together at count 2
    go[0] = 1'b1; step(); go[0] = 1'b0;
    en = 1'b1; step(); step();
    chk("t3_pre", cnt_of(0), 2);
    go[0] = 1'b1; step(); go[0] = 1'b0; en = 1'b0;
    chk("t3_cnt", cnt_of(0), 0);
    chk("t3_act", 32'(active[0]), 1);
    chk("t3_done", 32'(done[0]), 0);
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    chk("t3_stopped", 32'(active[0]), 0);

    // stop during play, then go+stop together
    len[47:32] = 16'd20;
    go[2] = 1'b1; step(); go[2] = 1'b0;
    en = 1'b1; repeat (7) step();
    chk("t5_pre", cnt_of(2), 7);
    stop[2] = 1'b1; step(); stop[2] = 1'b0;
    chk("t5_cnt", cnt_of(2), 0);
    chk("t5_act", 32'(active[2]), 0);
    chk("t5_done", 32'(done[2]), 0);
    step();
    chk("t5_idle_hold", cnt_of(2), 0);
    chk("t5_done2", 32'(done[2]), 0);
    go[2] = 1'b1; stop[2] = 1'b1; step(); go[2] = 1'b0; stop[2] = 1'b0;
    chk("t5_gs_act", 32'(active[2]), 1);
    chk("t5_gs_cnt", cnt_of(2), 0);
    step();
    chk("t5_gs_step", cnt_of(2), 1);
    en = 1'b0;
    stop[2] = 1'b1; step(); stop[2] = 1'b0;

    // loop channel: len3=2, en held for six ticks
    len[63:48] = 16'd2; loop[3] = 1'b1;
    go[3] = 1'b1; step(); go[3] = 1'b0;
    chk("t6_start", cnt_of(3), 0);
    en = 1'b1;
    begin
      int pulses = 0;
      for (int k = 1; k <= 6; k++) begin
        step();
        if (done[3]) pulses++;
`ifdef SAMPLE_LOOP_EN
        chk($sformatf("t6_cnt%0d", k), cnt_of(3), 32'(k % 2));
        chk($sformatf("t6_act%0d", k), 32'(active[3]), 1);
`else
        chk($sformatf("t6_cnt%0d", k), cnt_of(3), (k == 1) ? 1 : 0);
        chk($sformatf("t6_act%0d", k), 32'(active[3]), (k == 1) ? 1 : 0);
`endif
      end
`ifdef SAMPLE_LOOP_EN
      chk("t6_pulses", 32'(pulses), 3);
`else
      chk("t6_pulses", 32'(pulses), 1);
`endif
    end
    en = 1'b0; loop[3] = 1'b0;
    stop[3] = 1'b1; step(); stop[3] = 1'b0;

    // MAXCOUNT clamp: ch1 len=0, ch2 len=50000, both run to 43839
    len[31:16] = 16'd0; len[47:32] = 16'd50000;
    go[1] = 1'b1; go[2] = 1'b1; step(); go = '0;
    en = 1'b1;
    repeat (43839) step();
    chk("t4_len0_last", cnt_of(1), 43839);
    chk("t4_big_last", cnt_of(2), 43839);
    chk("t4_act", 32'(active[2:1]), 3);
    chk("t4_nodone", 32'(done[2:1]), 0);
    step();
    chk("t4_len0_wrap", cnt_of(1), 0);
    chk("t4_big_wrap", cnt_of(2), 0);
    chk("t4_done", 32'(done[2:1]), 3);
    chk("t4_idle", 32'(active[2:1]), 0);
    step();
    chk("t4_done_clr", 32'(done[2:1]), 0);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
